// File: rtl/fwd_operand_unit_pkg.sv
// Shared types and helpers for the operand-forwarding unit (package fwd_pkg).
package fwd_pkg;

    typedef enum logic {
        FWD_IDLE  = 1'b0,
        FWD_STALL = 1'b1
    } fwd_state_e;

    localparam int unsigned FWD_SRC_RF = 0;

    // op_src encodes "register file" plus one code per forwarding source.
    function automatic int unsigned fwd_sw(input int unsigned num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/fwd_operand_unit_if.sv
// Issue/operand bundle between the hazard pipeline and fwd_operand_unit.
interface fwd_operand_unit_if
    import fwd_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned NUM_SRC = 3
);
    localparam int unsigned SW = fwd_sw(NUM_SRC);

    logic                    issue_valid;
    logic                    issue_ready;
    logic [AW-1:0]           rs_addr;
    logic [XLEN-1:0]         rf_data;
    logic [NUM_SRC-1:0]      src_we;
    logic [NUM_SRC*AW-1:0]   src_rd;
    logic [NUM_SRC*XLEN-1:0] src_data;
    logic [NUM_SRC-1:0]      src_rdy;
    logic                    op_valid;
    logic [XLEN-1:0]         op_data;
    logic [SW-1:0]           op_src;
    logic                    stall;
    logic                    timeout_err;

    modport master (
        output issue_valid, rs_addr, rf_data, src_we, src_rd, src_data, src_rdy,
        input  issue_ready, op_valid, op_data, op_src, stall, timeout_err
    );

    modport slave (
        input  issue_valid, rs_addr, rf_data, src_we, src_rd, src_data, src_rdy,
        output issue_ready, op_valid, op_data, op_src, stall, timeout_err
    );

endinterface

// File: rtl/fwd_operand_unit_prio_sel.sv
// Combinational match and youngest-first priority select (module fwd_prio_sel).
module fwd_prio_sel
    import fwd_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned SW      = fwd_sw(NUM_SRC)
) (
    input  logic [AW-1:0]           rs_addr,
    input  logic [XLEN-1:0]         rf_data,
    input  logic [NUM_SRC-1:0]      src_we,
    input  logic [NUM_SRC*AW-1:0]   src_rd,
    input  logic [NUM_SRC*XLEN-1:0] src_data,
    input  logic [NUM_SRC-1:0]      src_rdy,
    output logic [SW-1:0]           win_code,
    output logic [XLEN-1:0]         sel_data,
    output logic                    not_ready
);

    logic found;

    always_comb begin
        found     = 1'b0;
        win_code  = SW'(FWD_SRC_RF);
        sel_data  = rf_data;
        not_ready = 1'b0;
        if (rs_addr == '0) begin
            sel_data = '0;
        end else begin
            // First hit from index 0 wins, so an older ready producer never masks a younger pending one.
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (!found && src_we[i] && (src_rd[i*AW +: AW] == rs_addr)) begin
                    found     = 1'b1;
                    win_code  = SW'(i + 1);
                    sel_data  = src_data[i*XLEN +: XLEN];
                    not_ready = ~src_rdy[i];
                end
            end
        end
    end

endmodule

// File: rtl/fwd_operand_unit.sv
// Operand-forwarding unit: priority select, load-use stall FSM, registered operand.
// Optional FWD_STATS_EN adds fwd_hit_cnt / stall_cyc_cnt counters.
module fwd_operand_unit
    import fwd_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned NUM_SRC   = 3,
    parameter int unsigned MAX_STALL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fwd_operand_unit_if.slave   bus
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]         fwd_hit_cnt,
    output logic [31:0]         stall_cyc_cnt
`endif
);

    localparam int unsigned SW = fwd_sw(NUM_SRC);
    localparam int unsigned CW = $clog2(MAX_STALL + 1);

    logic [SW-1:0]   win_code;
    logic [XLEN-1:0] sel_data;
    logic            not_ready;
    logic            hazard;
    logic            accept;

    fwd_prio_sel #(
        .XLEN    (XLEN),
        .AW      (AW),
        .NUM_SRC (NUM_SRC),
        .SW      (SW)
    ) u_prio_sel (
        .rs_addr   (bus.rs_addr),
        .rf_data   (bus.rf_data),
        .src_we    (bus.src_we),
        .src_rd    (bus.src_rd),
        .src_data  (bus.src_data),
        .src_rdy   (bus.src_rdy),
        .win_code  (win_code),
        .sel_data  (sel_data),
        .not_ready (not_ready)
    );

    assign hazard          = bus.issue_valid & not_ready;
    assign accept          = bus.issue_valid & ~hazard;
    assign bus.issue_ready = accept;
    assign bus.stall       = hazard;

    fwd_state_e      state_q, state_d;
    logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            timeout_q, timeout_d;
    logic            op_valid_q, op_valid_d;
    logic [XLEN-1:0] op_data_q, op_data_d;
    logic [SW-1:0]   op_src_q, op_src_d;

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            FWD_IDLE: begin
                if (hazard) begin
                    state_d     = FWD_STALL;
                    stall_cnt_d = CW'(1);
                end
            end
            FWD_STALL: begin
                // Covers both an accept and a withdrawn issue; a new younger pending match keeps counting.
                if (!hazard) begin
                    state_d     = FWD_IDLE;
                    stall_cnt_d = '0;
                end else if (stall_cnt_q != CW'(MAX_STALL)) begin
                    stall_cnt_d = stall_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d     = FWD_IDLE;
                stall_cnt_d = '0;
            end
        endcase
        timeout_d = timeout_q | (stall_cnt_d == CW'(MAX_STALL));
    end

    always_comb begin
        op_valid_d = 1'b0;
        op_data_d  = op_data_q;
        op_src_d   = op_src_q;
        if (accept) begin
            op_valid_d = 1'b1;
            op_data_d  = sel_data;
            op_src_d   = win_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FWD_IDLE;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
            op_valid_q  <= 1'b0;
            op_data_q   <= '0;
            op_src_q    <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
            op_valid_q  <= op_valid_d;
            op_data_q   <= op_data_d;
            op_src_q    <= op_src_d;
        end
    end

    assign bus.op_valid    = op_valid_q;
    assign bus.op_data     = op_data_q;
    assign bus.op_src      = op_src_q;
    assign bus.timeout_err = timeout_q;

`ifdef FWD_STATS_EN
    logic [31:0] fwd_hit_cnt_q, fwd_hit_cnt_d;
    logic [31:0] stall_cyc_cnt_q, stall_cyc_cnt_d;

    always_comb begin
        fwd_hit_cnt_d   = fwd_hit_cnt_q;
        stall_cyc_cnt_d = stall_cyc_cnt_q;
        if (accept && (win_code != SW'(FWD_SRC_RF))) begin
            fwd_hit_cnt_d = fwd_hit_cnt_q + 32'd1;
        end
        if (hazard) begin
            stall_cyc_cnt_d = stall_cyc_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit_cnt_q   <= '0;
            stall_cyc_cnt_q <= '0;
        end else begin
            fwd_hit_cnt_q   <= fwd_hit_cnt_d;
            stall_cyc_cnt_q <= stall_cyc_cnt_d;
        end
    end

    assign fwd_hit_cnt   = fwd_hit_cnt_q;
    assign stall_cyc_cnt = stall_cyc_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_operand_unit.sv
// Directed bench for fwd_operand_unit (default parameters, FWD_STATS_EN optional).
`define EDGE begin @(posedge clk); #1; end

module tb_fwd_operand_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  fwd_operand_unit_if #(.XLEN(32), .AW(5), .NUM_SRC(3)) bus ();

`ifdef FWD_STATS_EN
  logic [31:0] fwd_hit_cnt;
  logic [31:0] stall_cyc_cnt;
`endif

  fwd_operand_unit #(
    .XLEN      (32),
    .AW        (5),
    .NUM_SRC   (3),
    .MAX_STALL (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus)
`ifdef FWD_STATS_EN
    ,
    .fwd_hit_cnt   (fwd_hit_cnt),
    .stall_cyc_cnt (stall_cyc_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n            = 1'b0;
    bus.issue_valid  = 1'b0;
    bus.rs_addr      = '0;
    bus.rf_data      = '0;
    bus.src_we       = '0;
    bus.src_rd       = '0;
    bus.src_data     = '0;
    bus.src_rdy      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.op_valid !== 1'b0) begin n_fail++; $error("FAIL rst_op_valid observed=%0h expected=%0h", bus.op_valid, 1'b0); end
    n_tests++; if (bus.op_data !== 32'h0) begin n_fail++; $error("FAIL rst_op_data observed=%0h expected=%0h", bus.op_data, 32'h0); end
    n_tests++; if (bus.op_src !== 2'd0) begin n_fail++; $error("FAIL rst_op_src observed=%0h expected=%0h", bus.op_src, 2'd0); end
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $error("FAIL rst_timeout observed=%0h expected=%0h", bus.timeout_err, 1'b0); end
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $error("FAIL rst_stall observed=%0h expected=%0h", bus.stall, 1'b0); end
    rst_n = 1'b1;
    `EDGE

    // No match: register file wins
    bus.issue_valid = 1'b1;
    bus.rs_addr     = 5'd5;
    bus.rf_data     = 32'h11;
    #1;
    n_tests++; if (bus.issue_ready !== 1'b1) begin n_fail++; $error("FAIL nomatch_ready observed=%0h expected=%0h", bus.issue_ready, 1'b1); end
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $error("FAIL nomatch_stall observed=%0h expected=%0h", bus.stall, 1'b0); end
    `EDGE
    n_tests++; if (bus.op_valid !== 1'b1) begin n_fail++; $error("FAIL nomatch_valid observed=%0h expected=%0h", bus.op_valid, 1'b1); end
    n_tests++; if (bus.op_data !== 32'h11) begin n_fail++; $error("FAIL nomatch_data observed=%0h expected=%0h", bus.op_data, 32'h11); end
    n_tests++; if (bus.op_src !== 2'd0) begin n_fail++; $error("FAIL nomatch_src observed=%0h expected=%0h", bus.op_src, 2'd0); end
    bus.issue_valid = 1'b0;
    `EDGE
    n_tests++; if (bus.op_valid !== 1'b0) begin n_fail++; $error("FAIL idle_valid observed=%0h expected=%0h", bus.op_valid, 1'b0); end
    n_tests++; if (bus.op_data !== 32'h11) begin n_fail++; $error("FAIL idle_hold_data observed=%0h expected=%0h", bus.op_data, 32'h11); end

    // Priority: source 0 and 2 both write x7
    bus.src_rd      = {5'd7, 5'd0, 5'd7};
    bus.src_data    = {32'hBBBB, 32'h0, 32'hAAAA};
    bus.src_we      = 3'b101;
    bus.src_rdy     = 3'b111;
    bus.rs_addr     = 5'd7;
    bus.issue_valid = 1'b1;
    `EDGE
    n_tests++; if (bus.op_data !== 32'hAAAA) begin n_fail++; $error("FAIL prio_data observed=%0h expected=%0h", bus.op_data, 32'hAAAA); end
    n_tests++; if (bus.op_src !== 2'd1) begin n_fail++; $error("FAIL prio_src observed=%0h expected=%0h", bus.op_src, 2'd1); end
    bus.src_we = 3'b100;
    `EDGE
    n_tests++; if (bus.op_data !== 32'hBBBB) begin n_fail++; $error("FAIL oldest_data observed=%0h expected=%0h", bus.op_data, 32'hBBBB); end
    n_tests++; if (bus.op_src !== 2'd3) begin n_fail++; $error("FAIL oldest_src observed=%0h expected=%0h", bus.op_src, 2'd3); end
    bus.src_we  = 3'b101;
    bus.src_rd  = '0;
    bus.rs_addr = 5'd0;
    bus.rf_data = 32'h55;
    `EDGE
    n_tests++; if (bus.op_valid !== 1'b1) begin n_fail++; $error("FAIL x0_valid observed=%0h expected=%0h", bus.op_valid, 1'b1); end
    n_tests++; if (bus.op_data !== 32'h0) begin n_fail++; $error("FAIL x0_data observed=%0h expected=%0h", bus.op_data, 32'h0); end
    n_tests++; if (bus.op_src !== 2'd0) begin n_fail++; $error("FAIL x0_src observed=%0h expected=%0h", bus.op_src, 2'd0); end
    bus.issue_valid = 1'b0;
    `EDGE

    // Load-use: younger pending match, older ready match must not win
    bus.src_rd      = {5'd3, 5'd0, 5'd3};
    bus.src_data    = {32'h9999, 32'h0, 32'h0};
    bus.src_we      = 3'b101;
    bus.src_rdy     = 3'b100;
    bus.rs_addr     = 5'd3;
    bus.issue_valid = 1'b1;
    #1;
    n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $error("FAIL lu_stall observed=%0h expected=%0h", bus.stall, 1'b1); end
    n_tests++; if (bus.issue_ready !== 1'b0) begin n_fail++; $error("FAIL lu_ready observed=%0h expected=%0h", bus.issue_ready, 1'b0); end
    `EDGE
    n_tests++; if (bus.op_valid !== 1'b0) begin n_fail++; $error("FAIL lu_no_valid observed=%0h expected=%0h", bus.op_valid, 1'b0); end
    n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $error("FAIL lu_stall2 observed=%0h expected=%0h", bus.stall, 1'b1); end
    `EDGE
    bus.src_rdy  = 3'b111;
    bus.src_data = {32'h9999, 32'h0, 32'h1234};
    #1;
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $error("FAIL lu_clear_stall observed=%0h expected=%0h", bus.stall, 1'b0); end
    n_tests++; if (bus.issue_ready !== 1'b1) begin n_fail++; $error("FAIL lu_clear_ready observed=%0h expected=%0h", bus.issue_ready, 1'b1); end
    `EDGE
    n_tests++; if (bus.op_valid !== 1'b1) begin n_fail++; $error("FAIL lu_valid observed=%0h expected=%0h", bus.op_valid, 1'b1); end
    n_tests++; if (bus.op_data !== 32'h1234) begin n_fail++; $error("FAIL lu_data observed=%0h expected=%0h", bus.op_data, 32'h1234); end
    n_tests++; if (bus.op_src !== 2'd1) begin n_fail++; $error("FAIL lu_src observed=%0h expected=%0h", bus.op_src, 2'd1); end
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $error("FAIL lu_timeout observed=%0h expected=%0h", bus.timeout_err, 1'b0); end
    bus.issue_valid = 1'b0;
    bus.src_we      = '0;
    `EDGE

    // Timeout: hazard held for 6 cycles
    bus.src_rd      = {5'd0, 5'd4, 5'd0};
    bus.src_data    = {32'h0, 32'h77, 32'h0};
    bus.src_we      = 3'b010;
    bus.src_rdy     = 3'b101;
    bus.rs_addr     = 5'd4;
    bus.issue_valid = 1'b1;
    repeat (3) `EDGE
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $error("FAIL to_before observed=%0h expected=%0h", bus.timeout_err, 1'b0); end
    `EDGE
    n_tests++; if (bus.timeout_err !== 1'b1) begin n_fail++; $error("FAIL to_set observed=%0h expected=%0h", bus.timeout_err, 1'b1); end
    n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $error("FAIL to_still_stall observed=%0h expected=%0h", bus.stall, 1'b1); end
    repeat (2) `EDGE
    bus.src_rdy = 3'b111;
    `EDGE
    n_tests++; if (bus.op_valid !== 1'b1) begin n_fail++; $error("FAIL to_accept_valid observed=%0h expected=%0h", bus.op_valid, 1'b1); end
    n_tests++; if (bus.op_data !== 32'h77) begin n_fail++; $error("FAIL to_accept_data observed=%0h expected=%0h", bus.op_data, 32'h77); end
    n_tests++; if (bus.op_src !== 2'd2) begin n_fail++; $error("FAIL to_accept_src observed=%0h expected=%0h", bus.op_src, 2'd2); end
    n_tests++; if (bus.timeout_err !== 1'b1) begin n_fail++; $error("FAIL to_sticky observed=%0h expected=%0h", bus.timeout_err, 1'b1); end
    bus.issue_valid = 1'b0;
    bus.src_we      = '0;
    `EDGE
    n_tests++; if (bus.timeout_err !== 1'b1) begin n_fail++; $error("FAIL to_sticky_idle observed=%0h expected=%0h", bus.timeout_err, 1'b1); end

    // Issue withdrawn during STALL
    bus.src_rd      = {5'd0, 5'd0, 5'd9};
    bus.src_data    = {32'h0, 32'h0, 32'h99};
    bus.src_we      = 3'b001;
    bus.src_rdy     = 3'b110;
    bus.rs_addr     = 5'd9;
    bus.issue_valid = 1'b1;
    repeat (2) `EDGE
    bus.issue_valid = 1'b0;
    #1;
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $error("FAIL wd_stall observed=%0h expected=%0h", bus.stall, 1'b0); end
    n_tests++; if (bus.issue_ready !== 1'b0) begin n_fail++; $error("FAIL wd_ready observed=%0h expected=%0h", bus.issue_ready, 1'b0); end
    `EDGE
    n_tests++; if (bus.op_valid !== 1'b0) begin n_fail++; $error("FAIL wd_valid observed=%0h expected=%0h", bus.op_valid, 1'b0); end
    n_tests++; if (bus.op_data !== 32'h77) begin n_fail++; $error("FAIL wd_data_hold observed=%0h expected=%0h", bus.op_data, 32'h77); end
    n_tests++; if (bus.op_src !== 2'd2) begin n_fail++; $error("FAIL wd_src_hold observed=%0h expected=%0h", bus.op_src, 2'd2); end
`ifdef FWD_STATS_EN
    n_tests++; if (stall_cyc_cnt !== 32'd10) begin n_fail++; $error("FAIL stats_stall_cyc observed=%0h expected=%0h", stall_cyc_cnt, 32'd10); end
    n_tests++; if (fwd_hit_cnt !== 32'd4) begin n_fail++; $error("FAIL stats_hits observed=%0h expected=%0h", fwd_hit_cnt, 32'd4); end
`endif
    bus.src_we      = '0;
    bus.rs_addr     = 5'd10;
    bus.rf_data     = 32'h10;
    bus.issue_valid = 1'b1;
    #1;
    n_tests++; if (bus.issue_ready !== 1'b1) begin n_fail++; $error("FAIL post_wd_ready observed=%0h expected=%0h", bus.issue_ready, 1'b1); end
    `EDGE
    n_tests++; if (bus.op_data !== 32'h10) begin n_fail++; $error("FAIL post_wd_data observed=%0h expected=%0h", bus.op_data, 32'h10); end
    n_tests++; if (bus.op_src !== 2'd0) begin n_fail++; $error("FAIL post_wd_src observed=%0h expected=%0h", bus.op_src, 2'd0); end
    bus.issue_valid = 1'b0;
    `EDGE

    // Reset asserted mid-STALL
    bus.src_rd      = {5'd0, 5'd4, 5'd0};
    bus.src_data    = {32'h0, 32'h4444, 32'h0};
    bus.src_we      = 3'b010;
    bus.src_rdy     = 3'b101;
    bus.rs_addr     = 5'd4;
    bus.issue_valid = 1'b1;
    repeat (2) `EDGE
    n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $error("FAIL mid_stall observed=%0h expected=%0h", bus.stall, 1'b1); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.op_valid !== 1'b0) begin n_fail++; $error("FAIL mid_rst_valid observed=%0h expected=%0h", bus.op_valid, 1'b0); end
    n_tests++; if (bus.op_data !== 32'h0) begin n_fail++; $error("FAIL mid_rst_data observed=%0h expected=%0h", bus.op_data, 32'h0); end
    n_tests++; if (bus.op_src !== 2'd0) begin n_fail++; $error("FAIL mid_rst_src observed=%0h expected=%0h", bus.op_src, 2'd0); end
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $error("FAIL mid_rst_timeout observed=%0h expected=%0h", bus.timeout_err, 1'b0); end
`ifdef FWD_STATS_EN
    n_tests++; if (stall_cyc_cnt !== 32'd0) begin n_fail++; $error("FAIL mid_rst_stall_cyc observed=%0h expected=%0h", stall_cyc_cnt, 32'd0); end
    n_tests++; if (fwd_hit_cnt !== 32'd0) begin n_fail++; $error("FAIL mid_rst_hits observed=%0h expected=%0h", fwd_hit_cnt, 32'd0); end
`endif
    `EDGE
    rst_n = 1'b1;
    repeat (3) `EDGE
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $error("FAIL post_rst_cnt_fresh observed=%0h expected=%0h", bus.timeout_err, 1'b0); end
    bus.src_rdy = 3'b111;
    `EDGE
    n_tests++; if (bus.op_valid !== 1'b1) begin n_fail++; $error("FAIL post_rst_valid observed=%0h expected=%0h", bus.op_valid, 1'b1); end
    n_tests++; if (bus.op_data !== 32'h4444) begin n_fail++; $error("FAIL post_rst_data observed=%0h expected=%0h", bus.op_data, 32'h4444); end
    n_tests++; if (bus.op_src !== 2'd2) begin n_fail++; $error("FAIL post_rst_src observed=%0h expected=%0h", bus.op_src, 2'd2); end
    bus.issue_valid = 1'b0;
    `EDGE

    // Younger pending source joins an ongoing stall without restarting the count
    bus.src_rd      = {5'd0, 5'd6, 5'd6};
    bus.src_data    = {32'h0, 32'h66, 32'h60};
    bus.src_we      = 3'b010;
    bus.src_rdy     = 3'b101;
    bus.rs_addr     = 5'd6;
    bus.issue_valid = 1'b1;
    repeat (2) `EDGE
    bus.src_we  = 3'b011;
    bus.src_rdy = 3'b100;
    repeat (2) `EDGE
    n_tests++; if (bus.timeout_err !== 1'b1) begin n_fail++; $error("FAIL join_timeout observed=%0h expected=%0h", bus.timeout_err, 1'b1); end
    n_tests++; if (bus.op_valid !== 1'b0) begin n_fail++; $error("FAIL join_no_valid observed=%0h expected=%0h", bus.op_valid, 1'b0); end
    bus.src_rdy = 3'b111;
    `EDGE
    n_tests++; if (bus.op_data !== 32'h60) begin n_fail++; $error("FAIL join_data observed=%0h expected=%0h", bus.op_data, 32'h60); end
    n_tests++; if (bus.op_src !== 2'd1) begin n_fail++; $error("FAIL join_src observed=%0h expected=%0h", bus.op_src, 2'd1); end
    bus.issue_valid = 1'b0;
    `EDGE

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_operand_unit.md
Name: fwd_operand_unit

Overview:
Parametrised operand-forwarding unit for the RISC-V hazard pipeline; successor to the fixed 3-way forwarding mux.
- Selects one operand from the register file or any of NUM_SRC in-flight pipeline stages, using youngest-first priority.
- Detects not-yet-ready producers (load-use) and stalls issue via a small FSM.
- Delivers a registered operand with a valid pulse and a stall-timeout error flag.

Parameters:
XLEN, 32, operand data width
AW, 5, register address width
NUM_SRC, 3, number of forwarding sources; index 0 = youngest stage (EX/MEM), NUM_SRC-1 = oldest
MAX_STALL, 4, consecutive stall cycles before timeout_err sets
SW, $clog2(NUM_SRC+1), width of op_src (derived localparam)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  an instruction requests an operand this cycle
issue_ready  out  1  request accepted this cycle (combinational)
rs_addr  in  AW  source register index
rf_data  in  XLEN  register-file read data (default source)
src_we  in  NUM_SRC  per-source register write enable
src_rd  in  NUM_SRC*AW  per-source destination register, packed, source i at [i*AW +: AW]
src_data  in  NUM_SRC*XLEN  per-source result, packed likewise
src_rdy  in  NUM_SRC  per-source result available (0 = load data pending)
op_valid  out  1  op_data/op_src updated (one-cycle pulse)
op_data  out  XLEN  registered operand
op_src  out  SW  registered source code: 0 = register file, i+1 = source i
stall  out  1  hazard holding issue (combinational)
timeout_err  out  1  sticky: stall lasted MAX_STALL cycles

Behaviour:
- Match rule: source i matches when src_we[i]=1, src_rd[i]==rs_addr, and rs_addr!=0.
- Winner: the lowest-index match. If there is no match, the register file wins.
- rs_addr==0 always yields data 0 with op_src=0, regardless of rf_data or any source.
- hazard = issue_valid & (winner is source i) & !src_rdy[i].
  - An older ready match never overrides a younger not-ready match.
- issue_ready = issue_valid & !hazard. stall = hazard.
- Accept: on a clock edge with issue_ready=1:
  - op_data <= selected data; op_src <= winner code; op_valid <= 1.
  - Otherwise op_valid <= 0 and op_data/op_src hold.
  - Latency: 1 cycle from accept to op_valid.
- FSM states IDLE and STALL; stall_cnt is clog2(MAX_STALL+1) bits.
  - IDLE: hazard -> STALL, stall_cnt <= 1. Otherwise stay in IDLE.
  - STALL: sources are re-evaluated every cycle.
    - hazard clears (accept) -> IDLE, stall_cnt <= 0.
    - issue_valid drops -> IDLE, stall_cnt <= 0, no capture.
    - hazard persists -> stall_cnt increments, saturating at MAX_STALL.
  - When stall_cnt reaches MAX_STALL, timeout_err <= 1 and stays set until reset. Stalling continues; no forced accept.
- Simultaneous events: if the hazard clears in the same cycle a younger source newly matches, normal priority decides. A newly matching younger not-ready source keeps STALL without restarting stall_cnt.
- Reset (asynchronous, any state, including mid-stall): FSM=IDLE, stall_cnt=0, op_valid=0, op_data=0, op_src=0, timeout_err=0.

Optional Feature:
FWD_STATS_EN
- Defined: adds outputs fwd_hit_cnt [31:0] and stall_cyc_cnt [31:0].
  - fwd_hit_cnt increments on each accept with op_src!=0.
  - stall_cyc_cnt increments on each cycle with stall=1.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fwd_pkg holds:
  - FSM state enum (FWD_IDLE, FWD_STALL);
  - source-code constant FWD_SRC_RF=0;
  - function to compute SW from NUM_SRC.
- Sub-module fwd_prio_sel: purely combinational match plus youngest-first priority encoder.
  - Outputs winner code, selected data and a not-ready flag.
  - Instantiated once; FSM and output registers live in the top.

Test Plan:
1. Reset mid-STALL: assert rst_n=0 with stall=1 -> next cycle all outputs 0, FSM IDLE; after release, a clean issue accepts normally.
2. No match: rs_addr=5, rf_data=0x11, all src_we=0, issue_valid=1 -> issue_ready=1; next cycle op_valid=1, op_data=0x11, op_src=0.
3. Priority: sources 0 and 2 both write x7 (0xAAAA, 0xBBBB), all ready -> op_data=0xAAAA, op_src=1. Same stimulus with rs_addr=0 -> op_data=0, op_src=0.
4. Load-use: source 0 matches x3, src_rdy[0]=0 for 2 cycles, then 1 with data 0x1234 -> stall=1 for 2 cycles, accept on cycle 3, op_data=0x1234, op_src=1, timeout_err=0.
5. Timeout: hazard held 6 cycles, MAX_STALL=4 -> timeout_err rises after the 4th stall cycle and stays 1 after the hazard clears and the accept occurs.
6. Issue withdrawn during STALL: issue_valid drops -> FSM IDLE, op_valid=0, op_data unchanged. With FWD_STATS_EN, stall_cyc_cnt equals the number of stall cycles.
